msk_aes_stream_driver: RTL and testbench

Stream-side initiator for the masked 32-bit AES core. It packs 32-bit masked words from an upstream stream into the dense key and plaintext busses, then issues the run with the core's valid_in/in_ready handshake. It captures the masked ciphertext with the core's out_valid/out_ready handshake and streams it back out as four 32-bit masked words. It sits between a bus/DMA front end and the core instance, and performs no unmasking.

---
 rtl/msk_aes_stream_driver_if.sv | 52 +++++
 rtl/msk_aes_stream_driver.sv | 94 +++++++++
 tb/tb_msk_aes_stream_driver.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msk_aes_stream_driver_if.sv
// Stream, core-issue and core-result signals for msk_aes_stream_driver; NSHARES sets the share count.
// The key_reuse wire exists only when MSKDRV_KEY_REUSE_EN is defined.
`ifndef NSHARES
`define NSHARES 2
`endif

interface msk_aes_stream_driver_if #(parameter int d = `NSHARES);
  logic [32*d-1:0]  s_data;
  logic             s_valid;
  logic             s_ready;
`ifdef MSKDRV_KEY_REUSE_EN
  logic             key_reuse;
`endif
  logic             aes_valid_in;
  logic             aes_in_ready;
  logic [128*d-1:0] aes_sh_data_in;
  logic [256*d-1:0] aes_sh_key;
  logic             aes_out_valid;
  logic             aes_out_ready;
  logic [128*d-1:0] aes_sh_data_out;
  logic [32*d-1:0]  m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    input  s_data, s_valid,
`ifdef MSKDRV_KEY_REUSE_EN
    input  key_reuse,
`endif
    output s_ready,
    output aes_valid_in, aes_sh_data_in, aes_sh_key,
    input  aes_in_ready,
    input  aes_out_valid, aes_sh_data_out,
    output aes_out_ready,
    output m_data, m_valid,
    input  m_ready
  );

  modport slave (
    output s_data, s_valid,
`ifdef MSKDRV_KEY_REUSE_EN
    output key_reuse,
`endif
    input  s_ready,
    input  aes_valid_in, aes_sh_data_in, aes_sh_key,
    output aes_in_ready,
    output aes_out_valid, aes_sh_data_out,
    input  aes_out_ready,
    input  m_data, m_valid,
    output m_ready
  );
endinterface

// File: rtl/msk_aes_stream_driver.sv
// Packs 8 masked stream beats into key/plaintext, issues one AES-128 run, drains 4 masked result words.
// Outputs decode registered state only; stalls on s_valid/in_ready/m_ready. MSKDRV_KEY_REUSE_EN adds 4-beat key reuse.
`ifndef NSHARES
`define NSHARES 2
`endif

module msk_aes_stream_driver #(
  parameter int d = `NSHARES
) (
  input logic                      clk,
  input logic                      rst,
  msk_aes_stream_driver_if.master  bus
);
  localparam int W = 32*d;
  localparam int B = 128*d;

  localparam logic [0:0] LOAD  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] SEND  = 1'b1;

  logic [0:0]   in_state;
  logic [0:0]   out_state;
  logic [2:0]   beat;
  logic [2:0]   slot;
  logic [1:0]   k;
  logic [B-1:0] key_reg;
  logic [B-1:0] pt_reg;
  logic [B-1:0] ct_reg;

  assign bus.s_ready        = (in_state == LOAD);
  assign bus.aes_valid_in   = (in_state == ISSUE);
  assign bus.aes_sh_data_in = (in_state == ISSUE) ? pt_reg : {B{1'b0}};
  assign bus.aes_sh_key     = {{B{1'b0}}, ((in_state == ISSUE) ? key_reg : {B{1'b0}})};
  assign bus.aes_out_ready  = (out_state == EMPTY);
  assign bus.m_valid        = (out_state == SEND);
  assign bus.m_data         = (out_state == SEND) ? ct_reg[W*k +: W] : {W{1'b0}};

  // Slots 0-3 address key words, 4-7 plaintext words; a reuse beat 0 lands in slot 4.
  always_comb begin
    slot = beat;
`ifdef MSKDRV_KEY_REUSE_EN
    if (beat == 3'd0 && bus.key_reuse) slot = 3'd4;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_state <= LOAD;
      beat     <= 3'd0;
      key_reg  <= {B{1'b0}};
      pt_reg   <= {B{1'b0}};
    end else if (in_state == LOAD) begin
      if (bus.s_valid) begin
        if (slot[2]) pt_reg[W*slot[1:0] +: W]  <= bus.s_data;
        else         key_reg[W*slot[1:0] +: W] <= bus.s_data;
        if (slot == 3'd7) in_state <= ISSUE;
        else              beat     <= slot + 3'd1;
      end
    end else begin
      if (bus.aes_in_ready) begin
        in_state <= LOAD;
        beat     <= 3'd0;
        pt_reg   <= {B{1'b0}};
`ifndef MSKDRV_KEY_REUSE_EN
        key_reg  <= {B{1'b0}};
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_state <= EMPTY;
      k         <= 2'd0;
      ct_reg    <= {B{1'b0}};
    end else if (out_state == EMPTY) begin
      if (bus.aes_out_valid) begin
        ct_reg    <= bus.aes_sh_data_out;
        out_state <= SEND;
      end
    end else begin
      if (bus.m_ready) begin
        if (k == 2'd3) begin
          ct_reg    <= {B{1'b0}};
          k         <= 2'd0;
          out_state <= EMPTY;
        end else begin
          k <= k + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_msk_aes_stream_driver.sv
// Directed bench for msk_aes_stream_driver with d=2 and a table-driven stand-in for the masked AES core.
module tb_msk_aes_stream_driver;
  localparam int D = 2;
  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  msk_aes_stream_driver_if #(.d(D)) bus ();
  msk_aes_stream_driver #(.d(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] mask128(input logic [127:0] v, input logic [127:0] m);
    logic [255:0] r;
    for (int i = 0; i < 128; i++) begin
      r[2*i]   = m[i];
      r[2*i+1] = v[i] ^ m[i];
    end
    return r;
  endfunction

  function automatic logic [127:0] unmask128(input logic [255:0] x);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = x[2*i] ^ x[2*i+1];
    return r;
  endfunction

  function automatic logic [31:0] unmask32(input logic [63:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[2*i] ^ x[2*i+1];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] core_lookup(input logic [127:0] key, input logic [127:0] pt);
    if (key == KEY_A && pt == PT_A) return CT_A;
    if (key == KEY_B && pt == PT_B) return CT_B;
    return 128'h0;
  endfunction

  // Core stand-in: optional in_ready stall, fixed latency, then presents a freshly masked result.
  int stall_cycles = 0;
  int stall_cnt = 0;
  int lat = 0;
  bit in_fire = 0;
  bit out_fire = 0;
  int issues = 0;
  logic [127:0] seen_key = '0;
  logic [127:0] seen_pt = '0;
  logic [255:0] seen_key_hi = '0;
  logic [127:0] ct_q[$];

  initial begin
    bus.aes_in_ready = 1'b0;
    bus.aes_out_valid = 1'b0;
    bus.aes_sh_data_out = '0;
    forever begin
      @(negedge clk);
      if (in_fire) begin
        bus.aes_in_ready = 1'b0;
      end else if (bus.aes_valid_in && !bus.aes_in_ready) begin
        if (stall_cnt < stall_cycles) begin
          stall_cnt++;
        end else begin
          stall_cnt = 0;
          bus.aes_in_ready = 1'b1;
          seen_key = unmask128(bus.aes_sh_key[255:0]);
          seen_key_hi = bus.aes_sh_key[511:256];
          seen_pt = unmask128(bus.aes_sh_data_in);
          issues++;
          ct_q.push_back(core_lookup(seen_key, seen_pt));
        end
      end
      if (out_fire) begin
        bus.aes_out_valid = 1'b0;
        bus.aes_sh_data_out = '0;
        lat = 0;
      end else if (!bus.aes_out_valid && ct_q.size() > 0) begin
        if (lat < 3) begin
          lat++;
        end else begin
          bus.aes_out_valid = 1'b1;
          bus.aes_sh_data_out = mask128(ct_q.pop_front(), rnd128());
        end
      end
      in_fire = bus.aes_valid_in && bus.aes_in_ready;
      out_fire = bus.aes_out_valid && bus.aes_out_ready;
    end
  end

  // Downstream sink: records each recombined word and the cycle it transfers.
  bit sink_ready = 1'b1;
  logic [31:0] words[$];
  int word_cyc[$];

  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.m_ready = sink_ready;
      if (bus.m_valid && bus.m_ready) begin
        words.push_back(unmask32(bus.m_data));
        word_cyc.push_back(cyc);
      end
    end
  end

  task automatic send_beats(input logic [127:0] key, input logic [127:0] pt, input int n,
                            input bit gap, input bit reuse, output bit ok);
    logic [255:0] mk;
    logic [255:0] mp;
    int t;
    mk = mask128(key, rnd128());
    mp = mask128(pt, rnd128());
    ok = 1'b1;
    for (int b = 0; b < n; b++) begin
      if (reuse)      bus.s_data = mp[64*b +: 64];
      else if (b < 4) bus.s_data = mk[64*b +: 64];
      else            bus.s_data = mp[64*(b-4) +: 64];
      bus.s_valid = 1'b1;
`ifdef MSKDRV_KEY_REUSE_EN
      bus.key_reuse = reuse && (b == 0);
`endif
      t = 0;
      while (!bus.s_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!bus.s_ready) begin
        bus.s_valid = 1'b0;
        ok = 1'b0;
        return;
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
`ifdef MSKDRV_KEY_REUSE_EN
      bus.key_reuse = 1'b0;
`endif
      if (gap && b < n-1) @(negedge clk);
    end
  endtask

  task automatic wait_words(input int n, output bit ok);
    int t = 0;
    while (words.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    ok = (words.size() >= n);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b want=1", bus.s_ready); end
    total++; if (bus.aes_valid_in !== 1'b0) begin bad++; $display("FAIL rst_valid_in got=%b want=0", bus.aes_valid_in); end
    total++; if (bus.aes_out_ready !== 1'b1) begin bad++; $display("FAIL rst_out_ready got=%b want=1", bus.aes_out_ready); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b want=0", bus.m_valid); end
    total++; if (bus.m_data !== 64'h0) begin bad++; $display("FAIL rst_m_data got=%h want=0", bus.m_data); end
    total++; if (bus.aes_sh_data_in !== 256'h0) begin bad++; $display("FAIL rst_data_in got=%h want=0", bus.aes_sh_data_in); end
    total++; if (bus.aes_sh_key !== 512'h0) begin bad++; $display("FAIL rst_key got=%h want=0", bus.aes_sh_key); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    int t;
    logic [127:0] ct;
    ct = CT_A;
    words.delete(); word_cyc.delete();
    sink_ready = 1'b1;
    send_beats(KEY_A, PT_A, 8, 1'b0, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_send got=stalled want=accepted"); end
    total++; if (bus.aes_valid_in !== 1'b1) begin bad++; $display("FAIL basic_valid_in_rise got=%b want=1", bus.aes_valid_in); end
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL basic_s_ready_issue got=%b want=0", bus.s_ready); end
    t = 0;
    while (bus.aes_valid_in && t < 100) begin @(negedge clk); t++; end
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL basic_s_ready_return got=%b want=1", bus.s_ready); end
    total++; if (seen_key !== KEY_A) begin bad++; $display("FAIL basic_core_key got=%h want=%h", seen_key, KEY_A); end
    total++; if (seen_pt !== PT_A) begin bad++; $display("FAIL basic_core_pt got=%h want=%h", seen_pt, PT_A); end
    total++; if (seen_key_hi !== 256'h0) begin bad++; $display("FAIL basic_key_upper got=%h want=0", seen_key_hi); end
    wait_words(4, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_words got=%0d want=4", words.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (words[i] !== ct[32*i +: 32]) begin
        bad++; $display("FAIL basic_word%0d got=%h want=%h", i, words[i], ct[32*i +: 32]);
      end
    end
    repeat (2) @(negedge clk);
    total++; if (bus.m_valid !== 1'b0 || bus.m_data !== 64'h0) begin
      bad++; $display("FAIL basic_idle_m got=%b/%h want=0/0", bus.m_valid, bus.m_data);
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit held;
    int t;
    logic [63:0] snap;
    logic [127:0] ct;
    ct = CT_A;
    words.delete(); word_cyc.delete();
    sink_ready = 1'b0;
    send_beats(KEY_A, PT_A, 8, 1'b1, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_send got=stalled want=accepted"); end
    t = 0;
    while (!bus.m_valid && t < 200) begin @(negedge clk); t++; end
    snap = bus.m_data;
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.m_valid !== 1'b1 || bus.m_data !== snap) held = 1'b0;
      @(negedge clk);
    end
    total++; if (!held || snap === 64'h0) begin bad++; $display("FAIL stall_m_hold got=%b/%h want=1/stable", held, snap); end
    total++; if (words.size() != 0) begin bad++; $display("FAIL stall_no_early got=%0d want=0", words.size()); end
    sink_ready = 1'b1;
    wait_words(4, ok);
    repeat (3) @(negedge clk);
    total++; if (words.size() != 4) begin bad++; $display("FAIL stall_count got=%0d want=4", words.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (words[i] !== ct[32*i +: 32]) begin
        bad++; $display("FAIL stall_word%0d got=%h want=%h", i, words[i], ct[32*i +: 32]);
      end
    end
  endtask

  task automatic test_in_ready_stall();
    bit ok;
    bit held;
    logic [511:0] snap_key;
    logic [255:0] snap_pt;
    logic [127:0] ct;
    ct = CT_A;
    words.delete(); word_cyc.delete();
    sink_ready = 1'b1;
    stall_cycles = 50;
    send_beats(KEY_A, PT_A, 8, 1'b0, 1'b0, ok);
    snap_key = bus.aes_sh_key;
    snap_pt = bus.aes_sh_data_in;
    held = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.aes_valid_in !== 1'b1 || bus.s_ready !== 1'b0 ||
          bus.aes_sh_key !== snap_key || bus.aes_sh_data_in !== snap_pt) held = 1'b0;
      @(negedge clk);
    end
    total++; if (!held) begin bad++; $display("FAIL inrdy_hold got=changed want=stable valid_in=1 s_ready=0"); end
    stall_cycles = 0;
    wait_words(4, ok);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (words[i] !== ct[32*i +: 32]) begin
        bad++; $display("FAIL inrdy_word%0d got=%h want=%h", i, words[i], ct[32*i +: 32]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit held;
    int t;
    int rise;
    logic [127:0] ca;
    logic [127:0] cb;
    ca = CT_A;
    cb = CT_B;
    words.delete(); word_cyc.delete();
    sink_ready = 1'b0;
    send_beats(KEY_A, PT_A, 8, 1'b0, 1'b0, ok);
    t = 0;
    while (!bus.m_valid && t < 200) begin @(negedge clk); t++; end
    send_beats(KEY_B, PT_B, 8, 1'b0, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_send_second got=stalled want=accepted"); end
    t = 0;
    while (!bus.aes_out_valid && t < 200) begin @(negedge clk); t++; end
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.aes_out_ready !== 1'b0 || bus.aes_out_valid !== 1'b1) held = 1'b0;
      @(negedge clk);
    end
    total++; if (!held) begin bad++; $display("FAIL b2b_out_ready_hold got=not_held want=out_ready=0"); end
    sink_ready = 1'b1;
    rise = -1;
    t = 0;
    while (rise < 0 && t < 200) begin
      if (bus.aes_out_ready) rise = cyc;
      else begin @(negedge clk); t++; end
    end
    total++;
    if (word_cyc.size() < 4 || rise != word_cyc[3] + 1) begin
      bad++; $display("FAIL b2b_out_ready_rise got=%0d want=word3+1 (%0d words)", rise, word_cyc.size());
    end
    wait_words(8, ok);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (words[i] !== ca[32*i +: 32]) begin
        bad++; $display("FAIL b2b_first_word%0d got=%h want=%h", i, words[i], ca[32*i +: 32]);
      end
      total++;
      if (words[4+i] !== cb[32*i +: 32]) begin
        bad++; $display("FAIL b2b_second_word%0d got=%h want=%h", i, words[4+i], cb[32*i +: 32]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t;
    logic [127:0] ct;
    ct = CT_A;
    words.delete(); word_cyc.delete();
    sink_ready = 1'b0;
    send_beats(KEY_A, PT_A, 8, 1'b0, 1'b0, ok);
    t = 0;
    while (!bus.m_valid && t < 200) begin @(negedge clk); t++; end
    send_beats(KEY_B, PT_B, 5, 1'b0, 1'b0, ok);
    bus.s_data = 64'h0123456789abcdef;
    bus.s_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    total++; if (bus.m_valid !== 1'b0 || bus.m_data !== 64'h0) begin
      bad++; $display("FAIL rstmid_m got=%b/%h want=0/0", bus.m_valid, bus.m_data);
    end
    total++; if (bus.aes_out_ready !== 1'b1 || bus.s_ready !== 1'b1 || bus.aes_valid_in !== 1'b0) begin
      bad++; $display("FAIL rstmid_ctl got=%b%b%b want=110", bus.aes_out_ready, bus.s_ready, bus.aes_valid_in);
    end
    total++; if (bus.aes_sh_key !== 512'h0 || bus.aes_sh_data_in !== 256'h0) begin
      bad++; $display("FAIL rstmid_bus got=%h want=0", bus.aes_sh_data_in);
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    words.delete(); word_cyc.delete();
    sink_ready = 1'b1;
    @(negedge clk);
    send_beats(KEY_A, PT_A, 8, 1'b0, 1'b0, ok);
    wait_words(4, ok);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (words[i] !== ct[32*i +: 32]) begin
        bad++; $display("FAIL rstmid_word%0d got=%h want=%h", i, words[i], ct[32*i +: 32]);
      end
    end
  endtask

`ifdef MSKDRV_KEY_REUSE_EN
  task automatic test_key_reuse();
    bit ok;
    logic [127:0] ct;
    ct = CT_A;
    words.delete(); word_cyc.delete();
    sink_ready = 1'b1;
    send_beats(KEY_A, PT_A, 8, 1'b0, 1'b0, ok);
    wait_words(4, ok);
    words.delete(); word_cyc.delete();
    send_beats(128'h0, PT_A, 4, 1'b0, 1'b1, ok);
    total++; if (bus.aes_valid_in !== 1'b1) begin bad++; $display("FAIL reuse_issue got=%b want=1", bus.aes_valid_in); end
    wait_words(4, ok);
    total++; if (seen_key !== KEY_A) begin bad++; $display("FAIL reuse_key got=%h want=%h", seen_key, KEY_A); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (words[i] !== ct[32*i +: 32]) begin
        bad++; $display("FAIL reuse_word%0d got=%h want=%h", i, words[i], ct[32*i +: 32]);
      end
    end
  endtask
`endif

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
`ifdef MSKDRV_KEY_REUSE_EN
    bus.key_reuse = 1'b0;
`endif
    test_reset();
    test_basic();
    test_stall();
    test_in_ready_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef MSKDRV_KEY_REUSE_EN
    test_key_reuse();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
